// File: rtl/serial_add_pkg.sv
// Shared types and constants for the bit-serial adder controller.
//   state_e       : controller FSM state encoding
//   DEFAULT_WIDTH : default operand/sum width in bits
package serial_add_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage : serial_add_pkg

// File: rtl/full_adder_cell.sv
// 1-bit full adder built from two half adders and an OR for the carry.
// Purely combinational; the controller time-shares a single instance across all bit positions.
//   a_i, b_i : operand bits
//   c_i      : carry in
//   s_o      : sum bit
//   c_o      : carry out
module full_adder_cell (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);

  logic s0, c0, c1;

  half_adder u_ha0 (
    .a_i (a_i),
    .b_i (b_i),
    .s_o (s0),
    .c_o (c0)
  );

  half_adder u_ha1 (
    .a_i (s0),
    .b_i (c_i),
    .s_o (s_o),
    .c_o (c1)
  );

  // Both half-adder carries can never be set together, so OR is sufficient.
  assign c_o = c0 | c1;

endmodule : full_adder_cell

// File: rtl/half_adder.sv
// 1-bit half adder.
//   a_i, b_i : addend bits
//   s_o      : sum bit (a ^ b)
//   c_o      : carry bit (a & b)
module half_adder (
  input  logic a_i,
  input  logic b_i,
  output logic s_o,
  output logic c_o
);

  assign s_o = a_i ^ b_i;
  assign c_o = a_i & b_i;

endmodule : half_adder

// File: rtl/serial_add_ctrl.sv
// Bit-serial addition controller: one full-adder cell processes the operands LSB first,
// one bit per clock, producing {cout, sum} = a + b + cin.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   start : begin an addition (accepted only while ready)
//   ready : block idle, start will be accepted
//   abort : cancel an in-progress addition (RUN only)
//   a, b  : operands, sampled on the accepting edge
//   cin   : carry in, sampled on the accepting edge
//   busy  : addition in progress
//   done  : one-cycle pulse, sum/cout just updated
//   sum   : last completed sum
//   cout  : last completed carry out
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             ready,
  input  logic             abort,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   opa_q, opa_d;
  logic [WIDTH-1:0]   opb_q, opb_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic               carry_q, carry_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               cout_q, cout_d;

  logic               fa_s, fa_c;
  logic [WIDTH-1:0]   res_shift;
  logic               last_bit;

  full_adder_cell u_fa (
    .a_i (opa_q[0]),
    .b_i (opb_q[0]),
    .c_i (carry_q),
    .s_o (fa_s),
    .c_o (fa_c)
  );

  // Result fills from the MSB end so that after WIDTH shifts bit 0 sits at the LSB.
  always_comb begin
    res_shift            = res_q >> 1;
    res_shift[WIDTH-1]   = fa_s;
  end

  assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    res_d   = res_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    cout_d  = cout_q;

    unique case (state_q)
      IDLE: begin
        // start takes priority; abort is meaningless here.
        if (start) begin
          opa_d   = a;
          opb_d   = b;
          carry_d = cin;
          cnt_d   = '0;
          res_d   = '0;
          state_d = RUN;
        end
      end

      RUN: begin
        if (abort) begin
          opa_d   = '0;
          opb_d   = '0;
          res_d   = '0;
          carry_d = 1'b0;
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          res_d   = res_shift;
          opa_d   = opa_q >> 1;
          opb_d   = opb_q >> 1;
          carry_d = fa_c;
          cnt_d   = cnt_q + CNT_W'(1);
          if (last_bit) begin
            // Visible outputs change only on entry to DONE.
            sum_d   = res_shift;
            cout_d  = fa_c;
            state_d = DONE;
          end
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  assign ready = (state_q == IDLE);
  assign busy  = (state_q == RUN);
  assign done  = (state_q == DONE);
  assign sum   = sum_q;
  assign cout  = cout_q;

endmodule : serial_add_ctrl

// File: tb/tb_serial_add_ctrl.sv
// Directed self-checking bench for serial_add_ctrl (WIDTH = 8).
module tb_serial_add_ctrl;

  localparam int unsigned WIDTH = 8;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic             ready;
  logic             abort;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  int n_checks;
  int n_fail;

  serial_add_ctrl #(
    .WIDTH (WIDTH)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .ready (ready),
    .abort (abort),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge; sampling and driving happen 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Full transaction: one-cycle start pulse, wait for done, check latency and result.
  task automatic do_add(input logic [7:0] va, input logic [7:0] vb, input logic vc,
                        input logic [7:0] exp_sum, input logic exp_cout, input string tag);
    int n;
    a     = va;
    b     = vb;
    cin   = vc;
    start = 1'b1;
    step();
    start = 1'b0;
    a     = '0;
    b     = '0;
    cin   = 1'b0;
    check_eq({tag, " ready low"}, 32'(ready), 32'd0);
    check_eq({tag, " busy high"}, 32'(busy), 32'd1);
    n = 0;
    while (!done && n < 40) begin
      step();
      n++;
    end
    check_eq({tag, " latency"}, 32'(n), 32'(WIDTH));
    check_eq({tag, " sum"}, 32'(sum), 32'(exp_sum));
    check_eq({tag, " cout"}, 32'(cout), 32'(exp_cout));
    step();
    check_eq({tag, " done one cycle"}, 32'(done), 32'd0);
    check_eq({tag, " ready back"}, 32'(ready), 32'd1);
  endtask

  initial begin
    int dones;
    int t_prev;
    int n_int_bad;
    logic [7:0] cap_sum;
    logic       cap_cout;

    n_checks = 0;
    n_fail   = 0;
    start    = 1'b0;
    abort    = 1'b0;
    a        = '0;
    b        = '0;
    cin      = 1'b0;
    rst_n    = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    check_eq("reset ready", 32'(ready), 32'd1);
    check_eq("reset busy", 32'(busy), 32'd0);
    check_eq("reset done", 32'(done), 32'd0);
    check_eq("reset sum", 32'(sum), 32'd0);
    check_eq("reset cout", 32'(cout), 32'd0);
    #10 rst_n = 1'b1;
    step();

    do_add(8'h00, 8'h00, 1'b0, 8'h00, 1'b0, "zero");
    do_add(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, "ripple");
    do_add(8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1, "a5_5a_cin");

    // Start while busy is ignored.
    a = 8'h12; b = 8'h34; cin = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    step();
    check_eq("busy sum stable", 32'(sum), 32'h00);
    step();
    a = 8'hFF; b = 8'hFF; start = 1'b1;
    step();
    start = 1'b0;
    dones    = 0;
    cap_sum  = 8'hEE;
    cap_cout = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (done) begin
        dones++;
        cap_sum  = sum;
        cap_cout = cout;
      end
      step();
    end
    check_eq("ignored start dones", 32'(dones), 32'd1);
    check_eq("ignored start sum", 32'(cap_sum), 32'h46);
    check_eq("ignored start cout", 32'(cap_cout), 32'd0);
    check_eq("ignored start idle", 32'(ready), 32'd1);

    // Abort on the 4th RUN cycle.
    a = 8'h0F; b = 8'h01; cin = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    check_eq("abort ready", 32'(ready), 32'd1);
    check_eq("abort busy", 32'(busy), 32'd0);
    check_eq("abort sum kept", 32'(sum), 32'h46);
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      if (done) dones++;
      step();
    end
    check_eq("abort no done", 32'(dones), 32'd0);
    do_add(8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, "after abort");

    // Asynchronous reset between edges while running.
    a = 8'h33; b = 8'h44; start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    #2 rst_n = 1'b0;
    #1;
    check_eq("async rst busy", 32'(busy), 32'd0);
    check_eq("async rst ready", 32'(ready), 32'd1);
    check_eq("async rst done", 32'(done), 32'd0);
    check_eq("async rst sum", 32'(sum), 32'd0);
    check_eq("async rst cout", 32'(cout), 32'd0);
    #2 rst_n = 1'b1;
    do_add(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, "post reset");

    // Back-to-back with start held high.
    a = 8'h01; b = 8'h01; cin = 1'b0; start = 1'b1;
    dones     = 0;
    t_prev    = -1;
    n_int_bad = 0;
    for (int i = 0; i < 32; i++) begin
      step();
      if (done) begin
        dones++;
        check_eq("b2b sum", 32'(sum), 32'h02);
        if (t_prev >= 0 && (i - t_prev) != 10) n_int_bad++;
        t_prev = i;
      end
    end
    start = 1'b0;
    check_eq("b2b done count", 32'(dones), 32'd3);
    check_eq("b2b period", 32'(n_int_bad), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_serial_add_ctrl
